fetch_prefetch: RTL and testbench
=================================

# fetch_prefetch

Instruction fetch front end for the XRISC core. It walks a byte-wide instruction ROM one byte per cycle and assembles big-endian 32-bit instruction words, with the byte at the lowest address in bits 31:24. Assembled words are buffered in a small prefetch FIFO, and each is presented to the core with its PC over a valid/ready handshake. It sits directly upstream of the core's decode/controller stage, and a taken branch or jump flushes it through `redirect`.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch PC; bits 1:0 forced to 0 internally.
- `rom_addr`  out  32  byte address to the ROM: `fpc + byte_cnt`.
- `rom_data`  in  8  ROM byte at `rom_addr`; combinational, same cycle.
- `instr_valid`  out  1  FIFO head valid.
- `instr`  out  32  FIFO head instruction word; 0 when empty.
- `instr_pc`  out  32  FIFO head PC; 0 when empty.
- `instr_ready`  in  1  core accepts the head this cycle.
- `fetch_stall_cnt`  out  16  present only with `FETCH_STATS_EN`.

## Operation
- **State**
  - `fpc`: word-aligned fetch PC.
  - `byte_cnt`: 0..3.
  - `asm_word`: 24-bit partial word holding bytes 0..2.
  - FIFO of {instr, pc}.
- **Byte capture:** each cycle without redirect, `rom_data` is captured.
  - At `byte_cnt` 0..2: shift into `asm_word`, then `byte_cnt`++.
  - At `byte_cnt` 3: form the word `{asm_word, rom_data}` and push {word, `fpc`}.
    - On push: `fpc += 4`, `byte_cnt` = 0.
    - `fpc` wraps modulo 2^32.
- **Push legality:** the push at `byte_cnt`=3 happens only if the FIFO is not full, or a pop occurs in the same cycle.
  - Otherwise `byte_cnt` holds at 3 and `rom_addr` holds; the byte is re-read every cycle until the push succeeds.
- **Pop:** the head is removed when `instr_valid & instr_ready`.
  - `instr_ready` while empty is ignored.
- **Simultaneous push and pop:** count unchanged; legal even when full.
- **Redirect** has highest priority and applies in the same cycle:
  - FIFO emptied, and any push or pop that cycle is discarded;
  - partial word dropped and `byte_cnt` = 0;
  - `fpc` = `{redirect_pc[31:2], 2'b00}`.
- **Redirect held over several cycles:** fetch stays parked at `redirect_pc` and `instr_valid` stays 0.
- **Reset assertion (asynchronous, any time, including mid-word):**
  - `fpc` = `RESET_PC`, `byte_cnt` = 0, FIFO empty;
  - `rom_addr` = `RESET_PC`, `instr_valid` = 0, `instr` = 0, `instr_pc` = 0, `fetch_stall_cnt` = 0.

## Timing
- **Fetch rate:** one word per 4 cycles at most; the FIFO absorbs consumer stalls.
- **Latency:** `instr_valid` rises after the 4th rising edge following reset release or following a redirect cycle.
  - The ROM address sequence is `fpc`, `fpc`+1, `fpc`+2, `fpc`+3.
- **Outputs:**
  - `instr_valid`, `instr` and `instr_pc` are decoded from registered FIFO state only; there is no combinational path from `rom_data` or `instr_ready`.
  - `rom_addr` is combinational from registers.
- **Handshake:** once `instr_valid` is high, `instr` and `instr_pc` remain stable until a pop, redirect or reset.

## Configuration
- **`FETCH_STATS_EN` defined:**
  - adds the `fetch_stall_cnt` port, a 16-bit counter;
  - increments every cycle in which `instr_valid`=0 and `reset` is deasserted;
  - saturates at 16'hFFFF and is not cleared by redirect.
- **`FETCH_STATS_EN` undefined:** the port and the counter logic are absent, and all other behaviour is identical.

## Structure
- **Package `xrisc_fetch_pkg`:**
  - `fetch_entry_t` packed struct {`logic [31:0] instr`, `logic [31:0] pc`};
  - `localparam RESET_PC_DEFAULT = 32'h0`;
  - `localparam BYTES_PER_WORD = 4`.
- **Sub-module `fetch_fifo`:**
  - `DEPTH`-entry synchronous FIFO of `fetch_entry_t`;
  - push/pop/flush ports, and full/empty flags derived from a count of `$clog2(DEPTH)+1` bits;
  - pointers wrap modulo `DEPTH`.
- **Top level:** the byte-assembly FSM, `fpc`, redirect priority and stats counter.

## Test plan
1. **Basic fetch:** ROM[0..3]=00,50,04,13 and ROM[4..7]=00,A0,04,93; `instr_ready`=1 after reset → `instr_valid` after the 4th edge with `instr`=0x00500413, `instr_pc`=0; the next word 0x00A00493 with `instr_pc`=4 after 4 more edges.
2. **Backpressure:** hold `instr_ready`=0 with `DEPTH`=4 → four entries fill (PCs 0,4,8,12); `rom_addr` then stalls at 0x13; raise `instr_ready` → pops in PC order with no loss or duplication.
3. **Redirect:** assert `redirect` with `redirect_pc`=0x22 in the middle of assembling the word at PC 8 → FIFO empty next cycle, `rom_addr`=0x20, first new `instr_pc`=0x20 four edges later.
4. **Simultaneous events:**
   - FIFO full, push and pop in the same cycle → count stays `DEPTH`;
   - redirect in the same cycle as a pop → FIFO empty and the popped entry is not re-presented.
5. **Reset mid-operation:** drop `reset` asynchronously between edges with 2 entries queued → `instr_valid`, `instr` and `instr_pc` are 0 immediately and `rom_addr`=`RESET_PC`.
6. **`FETCH_STATS_EN` defined:**
   - first 4 cycles after reset → `fetch_stall_cnt`=4 before the first word is valid;
   - force the counter near its limit and starve the core → it holds at 0xFFFF.

Source files
------------

// File: rtl/xrisc_fetch_pkg.sv
// Shared types and constants for the XRISC instruction fetch front end.
package xrisc_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
  localparam int unsigned BYTES_PER_WORD   = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Byte position within the word currently being assembled
  typedef enum logic [1:0] {
    StByte0,
    StByte1,
    StByte2,
    StByte3
  } byte_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries with synchronous flush; flush beats push/pop.
module fetch_fifo
  import xrisc_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  fetch_entry_t mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntFull);
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// XRISC fetch front end: byte-serial ROM walk, big-endian word assembly, prefetch FIFO.
// Optional stall counter port/logic enabled by defining FETCH_STATS_EN.
module fetch_prefetch
  import xrisc_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] fetch_stall_cnt
`endif
);

  logic [31:0] fpc_q;
  byte_state_e byte_q;
  logic [23:0] asm_q;

  fetch_entry_t push_entry, head_entry;
  logic         fifo_full, fifo_empty;
  logic         push, pop;
  logic         unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign rom_addr   = fpc_q + {30'd0, byte_q};
  assign pop        = !fifo_empty && instr_ready;
  assign push       = (byte_q == StByte3) && !redirect && (!fifo_full || pop);
  assign push_entry = '{instr: {asm_q, rom_data}, pc: fpc_q};

  // Head outputs come only from registered FIFO state
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? 32'd0 : head_entry.instr;
  assign instr_pc    = fifo_empty ? 32'd0 : head_entry.pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q  <= RESET_PC;
      byte_q <= StByte0;
      asm_q  <= '0;
    end else if (redirect) begin
      fpc_q  <= {redirect_pc[31:2], 2'b00};
      byte_q <= StByte0;
      asm_q  <= '0;
    end else begin
      unique case (byte_q)
        StByte0: begin
          asm_q  <= {asm_q[15:0], rom_data};
          byte_q <= StByte1;
        end
        StByte1: begin
          asm_q  <= {asm_q[15:0], rom_data};
          byte_q <= StByte2;
        end
        StByte2: begin
          asm_q  <= {asm_q[15:0], rom_data};
          byte_q <= StByte3;
        end
        StByte3: begin
          // Without a push the last byte is simply re-read next cycle
          if (push) begin
            fpc_q  <= fpc_q + 32'(BYTES_PER_WORD);
            byte_q <= StByte0;
          end
        end
        default: byte_q <= StByte0;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (fifo_empty && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign fetch_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed self-checking bench for fetch_prefetch with a byte ROM model.
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] rom_addr;
  logic [7:0]  rom_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_stall_cnt;
`endif

  logic [7:0] rom [256];
  assign rom_data = rom[rom_addr[7:0]];

  int checks = 0;
  int failures = 0;

  logic [31:0] drain_pc  [6] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
  logic [31:0] drain_ins [6] = '{32'h00A00493, 32'h08090A0B, 32'h0C0D0E0F,
                                 32'h10111213, 32'h14151617, 32'h18191A1B};

  fetch_prefetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef FETCH_STATS_EN
    ,
    .fetch_stall_cnt (fetch_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves reset released at a falling edge, before the first active edge
  task automatic do_reset();
    reset       = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    rom[0] = 8'h00; rom[1] = 8'h50; rom[2] = 8'h04; rom[3] = 8'h13;
    rom[4] = 8'h00; rom[5] = 8'hA0; rom[6] = 8'h04; rom[7] = 8'h93;

    // Basic fetch with a consumer that is always ready
    do_reset();
    check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("rst_instr", instr, 32'd0);
    check_val("rst_pc", instr_pc, 32'd0);
    check_val("rst_addr", rom_addr, 32'd0);
`ifdef FETCH_STATS_EN
    check_val("stat_rst", {16'd0, fetch_stall_cnt}, 32'd0);
`endif
    instr_ready = 1'b1;
    step(3);
    check_val("lat_valid3", {31'd0, instr_valid}, 32'd0);
    step(1);
    check_val("w0_valid", {31'd0, instr_valid}, 32'd1);
    check_val("w0_instr", instr, 32'h00500413);
    check_val("w0_pc", instr_pc, 32'd0);
`ifdef FETCH_STATS_EN
    check_val("stat_4", {16'd0, fetch_stall_cnt}, 32'd4);
`endif
    step(4);
    check_val("w1_instr", instr, 32'h00A00493);
    check_val("w1_pc", instr_pc, 32'd4);

    // Backpressure: fill, stall, one push+pop while full, then drain
    do_reset();
    step(16);
    check_val("bp_valid", {31'd0, instr_valid}, 32'd1);
    check_val("bp_head_pc", instr_pc, 32'd0);
    step(3);
    check_val("bp_stall_a", rom_addr, 32'h13);
    step(2);
    check_val("bp_stall_b", rom_addr, 32'h13);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    check_val("pp_head_pc", instr_pc, 32'h4);
    step(5);
    check_val("pp_full_addr", rom_addr, 32'h17);
    check_val("pp_full_pc", instr_pc, 32'h4);
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check_val($sformatf("drain_pc%0d", k), instr_pc, drain_pc[k]);
      check_val($sformatf("drain_ins%0d", k), instr, drain_ins[k]);
      step(1);
    end

    // Redirect mid-word with entries queued, held for three cycles
    do_reset();
    step(10);
    check_val("rd_pre_pc", instr_pc, 32'd0);
    check_val("rd_pre_addr", rom_addr, 32'h0A);
    redirect    = 1'b1;
    redirect_pc = 32'h22;
    step(1);
    check_val("rd_empty", {31'd0, instr_valid}, 32'd0);
    check_val("rd_addr", rom_addr, 32'h20);
    step(2);
    check_val("rd_hold_addr", rom_addr, 32'h20);
    check_val("rd_hold_valid", {31'd0, instr_valid}, 32'd0);
    redirect = 1'b0;
    step(3);
    check_val("rd_lat3", {31'd0, instr_valid}, 32'd0);
    step(1);
    check_val("rd_new_pc", instr_pc, 32'h20);
    check_val("rd_new_instr", instr, 32'h20212223);

    // Redirect in the same cycle as a pop
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step(1);
    redirect = 1'b0;
    check_val("rp_empty", {31'd0, instr_valid}, 32'd0);
    check_val("rp_addr", rom_addr, 32'h40);
    step(4);
    check_val("rp_new_pc", instr_pc, 32'h40);
    check_val("rp_new_instr", instr, 32'h40414243);

    // Asynchronous reset between edges with two entries queued
    instr_ready = 1'b0;
    step(4);
    check_val("ar_pre_pc", instr_pc, 32'h40);
    check_val("ar_pre_addr", rom_addr, 32'h48);
    #2 reset = 1'b0;
    #1;
    check_val("ar_valid", {31'd0, instr_valid}, 32'd0);
    check_val("ar_instr", instr, 32'd0);
    check_val("ar_pc", instr_pc, 32'd0);
    check_val("ar_addr", rom_addr, 32'd0);
    @(negedge clk);
    reset = 1'b1;

`ifdef FETCH_STATS_EN
    // Starve the core by parking fetch under redirect until the counter saturates
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'd0;
    step(65540);
    check_val("stat_sat", {16'd0, fetch_stall_cnt}, 32'hFFFF);
    step(3);
    check_val("stat_sat_hold", {16'd0, fetch_stall_cnt}, 32'hFFFF);
    redirect = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
